// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit between the RV32I core data port and a
// handshaked word bus. It generates byte-lane strobes and lane-replicated
// store data, sign/zero-extends load data, rejects misaligned or illegal
// accesses, and stalls the core until the bus access completes.
// Optional bus watchdog: define DMEM_TIMEOUT_EN to abort after
// TIMEOUT_CYCLES bus-wait cycles.
module dmem_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_re,
  input  logic        mem_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        misalign,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t      state;
  logic [2:0]  acc_f3;
  logic [1:0]  acc_off;

  logic        req;
  logic        is_store;
  logic        legal;
  logic        aligned;
  logic [3:0]  st_strb;
  logic [31:0] st_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  logic        timeout_hit;

  // Core is held while a request waits in IDLE and for the whole bus wait
  assign stall = ((state == S_IDLE) & (mem_re | mem_we)) | (state == S_BUSY);

  // Decode request: a simultaneous load and store is treated as a store
  always_comb begin
    req      = mem_re | mem_we;
    is_store = mem_we;
    legal    = 1'b0;
    aligned  = 1'b1;
    case (funct3)
      3'b000: legal = 1'b1;
      3'b001: begin
        legal   = 1'b1;
        aligned = ~addr[0];
      end
      3'b010: begin
        legal   = 1'b1;
        aligned = (addr[1:0] == 2'b00);
      end
      3'b100: legal = ~is_store;
      3'b101: begin
        legal   = ~is_store;
        aligned = ~addr[0];
      end
      default: legal = 1'b0;
    endcase
  end

  // Store lane strobes and data replicated across all lanes of that size
  always_comb begin
    st_strb = 4'b1111;
    st_data = wdata;
    case (funct3[1:0])
      2'b00: begin
        st_strb = 4'b0001 << addr[1:0];
        st_data = {4{wdata[7:0]}};
      end
      2'b01: begin
        st_strb = 4'b0011 << {addr[1], 1'b0};
        st_data = {2{wdata[15:0]}};
      end
      default: begin
        st_strb = 4'b1111;
        st_data = wdata;
      end
    endcase
  end

  // Load lane select and extension from the latched size/offset
  always_comb begin
    ld_byte = bus_rdata[{acc_off, 3'b000} +: 8];
    ld_half = bus_rdata[{acc_off[1], 4'b0000} +: 16];
    case (acc_f3)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_ext = {24'h000000, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_ext = {16'h0000, ld_half};
      default: ld_ext = bus_rdata;
    endcase
  end

`ifdef DMEM_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt;

  // Bus-wait counter: zero outside BUSY, counts BUSY cycles without ack
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state != S_BUSY) begin
      wait_cnt <= '0;
    end else if (!bus_ack) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // Expiry on the cycle that would make the count reach TIMEOUT_CYCLES
  assign timeout_hit = (wait_cnt == CNT_LAST);
`else
  // Watchdog absent: BUSY waits indefinitely for the ack
  assign timeout_hit = 1'b0;

  // TIMEOUT_CYCLES is accepted but has no effect in this build
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
  end
`endif

  // Access sequencer: launch in IDLE, wait for ack in BUSY, one DONE cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_wstrb <= 4'b0000;
      bus_addr  <= 32'h0;
      bus_wdata <= 32'h0;
      misalign  <= 1'b0;
      bus_err   <= 1'b0;
      rdata     <= 32'h0;
      acc_f3    <= 3'b000;
      acc_off   <= 2'b00;
    end else begin
      case (state)
        S_IDLE: begin
          misalign <= 1'b0;
          bus_err  <= 1'b0;
          if (req) begin
            if (legal && aligned) begin
              bus_req   <= 1'b1;
              bus_we    <= is_store;
              bus_addr  <= {addr[31:2], 2'b00};
              bus_wstrb <= is_store ? st_strb : 4'b0000;
              bus_wdata <= st_data;
              acc_f3    <= funct3;
              acc_off   <= addr[1:0];
              state     <= S_BUSY;
            end else begin
              misalign <= 1'b1;
              rdata    <= 32'h0;
              state    <= S_DONE;
            end
          end
        end
        S_BUSY: begin
          if (bus_ack) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_wstrb <= 4'b0000;
            if (!bus_we) begin
              rdata <= ld_ext;
            end
            state <= S_DONE;
          end else if (timeout_hit) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_wstrb <= 4'b0000;
            bus_err   <= 1'b1;
            rdata     <= 32'h0;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          misalign <= 1'b0;
          bus_err  <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: scoreboard bench for dmem_lsu. Expected results are pushed
// when an access is issued and popped when the DUT reaches its DONE cycle.
`timescale 1ns/1ps
module tb_dmem_lsu;

`ifdef DMEM_TIMEOUT_EN
  localparam int unsigned TO = 4;
`else
  localparam int unsigned TO = 255;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_re, mem_we;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, rdata;
  logic        stall, misalign, bus_err, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ack;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  dmem_lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .mem_re(mem_re), .mem_we(mem_we),
    .funct3(funct3), .addr(addr), .wdata(wdata), .rdata(rdata),
    .stall(stall), .misalign(misalign), .bus_err(bus_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  typedef struct {
    logic re, we; logic [2:0] f3; logic [31:0] a, wd, word; int waits;
  } txn_t;

  typedef struct {
    int stalls; logic req; logic [31:0] baddr; logic [3:0] strb; logic bwe;
    logic [31:0] bwdata; logic [31:0] rdata; logic mis, err;
  } exp_t;

  typedef struct {
    int stalls; logic req; logic [31:0] baddr; logic [3:0] strb; logic bwe;
    logic [31:0] bwdata; logic unstable; logic [31:0] rdata; logic mis, err;
    logic post_mis, post_err, post_req;
  } obs_t;

  exp_t        sb[$];
  logic [31:0] model_rd;

  function automatic txn_t mk(input logic re, input logic we, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] word, input int waits);
    txn_t t;
    t.re = re; t.we = we; t.f3 = f3; t.a = a; t.wd = wd; t.word = word; t.waits = waits;
    return t;
  endfunction

  // Reference model of one access; prev is the rdata value before it
  function automatic exp_t model(input txn_t t, input logic [31:0] prev);
    exp_t e;
    int n;
    logic [31:0] v;
    logic [1:0] off;
    logic lg;
    n   = 1 << t.f3[1:0];
    off = t.a[1:0];
    lg  = t.we ? (t.f3 <= 3'd2) : (t.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    e.stalls = 1; e.req = 1'b0; e.baddr = 32'h0; e.strb = 4'h0; e.bwe = 1'b0;
    e.bwdata = 32'h0; e.rdata = 32'h0; e.mis = 1'b1; e.err = 1'b0;
    if (lg && ((int'(off) % n) == 0)) begin
      e.stalls = 2 + t.waits;
      e.req    = 1'b1;
      e.baddr  = t.a & 32'hFFFF_FFFC;
      e.mis    = 1'b0;
      e.bwe    = t.we;
      if (t.we) begin
        e.strb   = 4'(((1 << n) - 1) << off);
        e.bwdata = (n == 1) ? {4{t.wd[7:0]}} : (n == 2) ? {2{t.wd[15:0]}} : t.wd;
        e.rdata  = prev;
      end else begin
        v = t.word >> (8 * off);
        if (n == 1)      e.rdata = t.f3[2] ? (v & 32'hFF)   : 32'($signed(v[7:0]));
        else if (n == 2) e.rdata = t.f3[2] ? (v & 32'hFFFF) : 32'($signed(v[15:0]));
        else             e.rdata = v;
      end
`ifdef DMEM_TIMEOUT_EN
      if (t.waits < 0 || t.waits >= int'(TO)) begin
        e.stalls = 1 + int'(TO);
        e.err    = 1'b1;
        e.rdata  = 32'h0;
      end
`endif
    end
    return e;
  endfunction

  // Drive one access as the core and act as the bus slave until DONE
  task automatic run_access(input txn_t t, output obs_t o);
    int nbusy;
    bit done;
    o.stalls = 0; o.req = 1'b0; o.baddr = 32'h0; o.strb = 4'h0; o.bwe = 1'b0;
    o.bwdata = 32'h0; o.unstable = 1'b0; o.rdata = 32'h0; o.mis = 1'b0; o.err = 1'b0;
    nbusy = 0;
    done = 1'b0;
    @(negedge clock);
    mem_re = t.re; mem_we = t.we; funct3 = t.f3; addr = t.a; wdata = t.wd;
    bus_rdata = t.word;
    for (int c = 0; c < 300 && !done; c++) begin
      if (c > 0) @(negedge clock);
      #1;
      if (stall) begin
        o.stalls++;
        if (bus_req) begin
          nbusy++;
          if (!o.req) begin
            o.req = 1'b1; o.baddr = bus_addr; o.strb = bus_wstrb;
            o.bwe = bus_we; o.bwdata = bus_wdata;
          end else if (bus_addr !== o.baddr || bus_wstrb !== o.strb ||
                       bus_we !== o.bwe || bus_wdata !== o.bwdata) begin
            o.unstable = 1'b1;
          end
          bus_ack = (t.waits >= 0) && (nbusy > t.waits);
        end else begin
          bus_ack = 1'b0;
        end
      end else begin
        done = 1'b1;
        bus_ack = 1'b0;
        o.rdata = rdata; o.mis = misalign; o.err = bus_err;
      end
    end
    bus_ack = 1'b0;
    @(negedge clock);
    mem_re = 1'b0; mem_we = 1'b0;
    #1;
    o.post_mis = misalign; o.post_err = bus_err; o.post_req = bus_req;
    if (!done) o.stalls = -1;
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_re = 1'b0; mem_we = 1'b0; funct3 = 3'b000; addr = 32'h0;
    wdata = 32'h0; bus_rdata = 32'h0; bus_ack = 1'b0;
    #3;
    checks++;
    if ({bus_req, bus_we, bus_wstrb, misalign, bus_err, stall} !== 9'b0 ||
        rdata !== 32'h0 || bus_addr !== 32'h0 || bus_wdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs got req=%b we=%b strb=%b mis=%b err=%b stall=%b rdata=%h addr=%h wdata=%h exp all zero",
               bus_req, bus_we, bus_wstrb, misalign, bus_err, stall, rdata, bus_addr, bus_wdata);
    end
    mem_re = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      failures++;
      $display("FAIL reset_idle_stall got=%b exp=1", stall);
    end
    mem_re = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    model_rd = 32'h0;
  endtask

  task automatic test_loads();
    txn_t tv[$];
    obs_t o;
    exp_t e;
    tv.push_back(mk(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0));
    tv.push_back(mk(1, 0, 3'b000, 32'h103, 32'h0, 32'h80112233, 0));
    tv.push_back(mk(1, 0, 3'b100, 32'h103, 32'h0, 32'h80112233, 0));
    tv.push_back(mk(1, 0, 3'b001, 32'h102, 32'h0, 32'h80112233, 0));
    tv.push_back(mk(1, 0, 3'b101, 32'h102, 32'h0, 32'h80112233, 1));
    tv.push_back(mk(1, 0, 3'b000, 32'h100, 32'h0, 32'h80112233, 0));
    tv.push_back(mk(1, 0, 3'b100, 32'h101, 32'h0, 32'h801122F3, 2));
    tv.push_back(mk(1, 0, 3'b001, 32'h100, 32'h0, 32'h0000F00D, 0));
    tv.push_back(mk(1, 0, 3'b010, 32'h1FC, 32'h0, 32'h13579BDF, 5));
    tv.push_back(mk(1, 0, 3'b010, 32'h300, 32'h0, 32'h2468ACE0, 20));
    foreach (tv[i]) begin
      sb.push_back(model(tv[i], model_rd));
      run_access(tv[i], o);
      e = sb.pop_front();
      model_rd = e.rdata;
      checks++;
      if (o.stalls !== e.stalls) begin
        failures++; $display("FAIL load[%0d] stall_cycles got=%0d exp=%0d", i, o.stalls, e.stalls);
      end
      checks++;
      if ({o.rdata, o.mis, o.err} !== {e.rdata, e.mis, e.err}) begin
        failures++; $display("FAIL load[%0d] result got rdata=%h mis=%b err=%b exp rdata=%h mis=%b err=%b",
                             i, o.rdata, o.mis, o.err, e.rdata, e.mis, e.err);
      end
      checks++;
      if ({o.req, o.baddr, o.strb, o.bwe, o.unstable} !== {e.req, e.baddr, e.strb, e.bwe, 1'b0}) begin
        failures++; $display("FAIL load[%0d] bus got req=%b addr=%h strb=%b we=%b unstable=%b exp req=%b addr=%h strb=%b we=%b",
                             i, o.req, o.baddr, o.strb, o.bwe, o.unstable, e.req, e.baddr, e.strb, e.bwe);
      end
      checks++;
      if ({o.post_mis, o.post_err, o.post_req} !== 3'b000) begin
        failures++; $display("FAIL load[%0d] after_done got mis=%b err=%b req=%b exp 0 0 0", i, o.post_mis, o.post_err, o.post_req);
      end
    end
  endtask

  task automatic test_reset_busy();
    @(negedge clock);
    mem_re = 1'b1; mem_we = 1'b0; funct3 = 3'b010; addr = 32'h100; bus_rdata = 32'hAAAA5555;
    repeat (3) @(negedge clock);
    reset = 1'b1; mem_re = 1'b0;
    #1;
    checks++;
    if ({bus_req, stall, rdata} !== {1'b0, 1'b0, 32'h0}) begin
      failures++; $display("FAIL reset_busy got req=%b stall=%b rdata=%h exp 0 0 00000000", bus_req, stall, rdata);
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    bus_ack = 1'b1;
    @(negedge clock);
    bus_ack = 1'b0;
    #1;
    checks++;
    if ({bus_req, stall, misalign, rdata} !== {1'b0, 1'b0, 1'b0, 32'h0}) begin
      failures++; $display("FAIL stray_ack got req=%b stall=%b mis=%b rdata=%h exp 0 0 0 00000000",
                           bus_req, stall, misalign, rdata);
    end
    mem_re = 1'b1;
    @(negedge clock);
    checks++;
    if ({bus_req, stall} !== 2'b11) begin
      failures++; $display("FAIL relaunch_after_reset got req=%b stall=%b exp 1 1", bus_req, stall);
    end
    bus_ack = 1'b1;
    @(negedge clock);
    bus_ack = 1'b0; mem_re = 1'b0;
    @(negedge clock);
    model_rd = 32'hAAAA5555;
  endtask

  task automatic test_stores();
    txn_t tv[$];
    obs_t o;
    exp_t e;
    tv.push_back(mk(0, 1, 3'b000, 32'h201, 32'h000000A5, 32'h0, 0));
    tv.push_back(mk(0, 1, 3'b001, 32'h202, 32'h00001234, 32'h0, 0));
    tv.push_back(mk(0, 1, 3'b010, 32'h204, 32'hCAFEF00D, 32'h0, 3));
    tv.push_back(mk(0, 1, 3'b000, 32'h203, 32'h1234565A, 32'h0, 0));
    tv.push_back(mk(0, 1, 3'b001, 32'h200, 32'hFFFF8765, 32'h0, 1));
    tv.push_back(mk(1, 1, 3'b000, 32'h200, 32'h0000003C, 32'h0, 0));
    foreach (tv[i]) begin
      sb.push_back(model(tv[i], model_rd));
      run_access(tv[i], o);
      e = sb.pop_front();
      model_rd = e.rdata;
      checks++;
      if (o.stalls !== e.stalls) begin
        failures++; $display("FAIL store[%0d] stall_cycles got=%0d exp=%0d", i, o.stalls, e.stalls);
      end
      checks++;
      if ({o.rdata, o.mis, o.err} !== {e.rdata, e.mis, e.err}) begin
        failures++; $display("FAIL store[%0d] result got rdata=%h mis=%b err=%b exp rdata=%h mis=%b err=%b",
                             i, o.rdata, o.mis, o.err, e.rdata, e.mis, e.err);
      end
      checks++;
      if ({o.req, o.baddr, o.strb, o.bwe, o.unstable} !== {e.req, e.baddr, e.strb, e.bwe, 1'b0}) begin
        failures++; $display("FAIL store[%0d] bus got req=%b addr=%h strb=%b we=%b unstable=%b exp req=%b addr=%h strb=%b we=%b",
                             i, o.req, o.baddr, o.strb, o.bwe, o.unstable, e.req, e.baddr, e.strb, e.bwe);
      end
      checks++;
      if (o.bwdata !== e.bwdata) begin
        failures++; $display("FAIL store[%0d] bus_wdata got=%h exp=%h", i, o.bwdata, e.bwdata);
      end
    end
  endtask

  task automatic test_misalign();
    txn_t tv[$];
    obs_t o;
    exp_t e;
    tv.push_back(mk(1, 0, 3'b010, 32'h102, 32'h0, 32'h11111111, 0));
    tv.push_back(mk(0, 1, 3'b001, 32'h101, 32'h5555, 32'h0, 0));
    tv.push_back(mk(1, 0, 3'b011, 32'h100, 32'h0, 32'h22222222, 0));
    tv.push_back(mk(0, 1, 3'b100, 32'h100, 32'h77, 32'h0, 0));
    tv.push_back(mk(1, 0, 3'b101, 32'h103, 32'h0, 32'h33333333, 0));
    tv.push_back(mk(1, 0, 3'b110, 32'h104, 32'h0, 32'h44444444, 0));
    foreach (tv[i]) begin
      sb.push_back(model(tv[i], model_rd));
      run_access(tv[i], o);
      e = sb.pop_front();
      model_rd = e.rdata;
      checks++;
      if ({o.stalls, o.req} !== {e.stalls, e.req}) begin
        failures++; $display("FAIL misalign[%0d] stall_req got stalls=%0d req=%b exp stalls=%0d req=%b",
                             i, o.stalls, o.req, e.stalls, e.req);
      end
      checks++;
      if ({o.rdata, o.mis, o.err} !== {e.rdata, e.mis, e.err}) begin
        failures++; $display("FAIL misalign[%0d] result got rdata=%h mis=%b err=%b exp rdata=%h mis=%b err=%b",
                             i, o.rdata, o.mis, o.err, e.rdata, e.mis, e.err);
      end
      checks++;
      if ({o.post_mis, o.post_err, o.post_req} !== 3'b000) begin
        failures++; $display("FAIL misalign[%0d] after_done got mis=%b err=%b req=%b exp 0 0 0", i, o.post_mis, o.post_err, o.post_req);
      end
    end
  endtask

  task automatic test_mixed();
    obs_t o;
    exp_t e;
    txn_t t;
    logic [1:0] rw;
    for (int i = 0; i < 24; i++) begin
      rw = 2'($urandom_range(1, 3));
      t = mk(rw[0], rw[1], 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
             int'($urandom_range(0, 3)));
      sb.push_back(model(t, model_rd));
      run_access(t, o);
      e = sb.pop_front();
      model_rd = e.rdata;
      checks++;
      if (o.stalls !== e.stalls) begin
        failures++; $display("FAIL mixed[%0d] stall_cycles got=%0d exp=%0d", i, o.stalls, e.stalls);
      end
      checks++;
      if ({o.rdata, o.mis, o.err} !== {e.rdata, e.mis, e.err}) begin
        failures++; $display("FAIL mixed[%0d] result got rdata=%h mis=%b err=%b exp rdata=%h mis=%b err=%b",
                             i, o.rdata, o.mis, o.err, e.rdata, e.mis, e.err);
      end
      checks++;
      if ({o.req, o.baddr, o.strb, o.bwe, o.unstable} !== {e.req, e.baddr, e.strb, e.bwe, 1'b0}) begin
        failures++; $display("FAIL mixed[%0d] bus got req=%b addr=%h strb=%b we=%b unstable=%b exp req=%b addr=%h strb=%b we=%b",
                             i, o.req, o.baddr, o.strb, o.bwe, o.unstable, e.req, e.baddr, e.strb, e.bwe);
      end
      if (e.bwe) begin
        checks++;
        if (o.bwdata !== e.bwdata) begin
          failures++; $display("FAIL mixed[%0d] bus_wdata got=%h exp=%h", i, o.bwdata, e.bwdata);
        end
      end
    end
  endtask

`ifdef DMEM_TIMEOUT_EN
  task automatic test_timeout();
    txn_t tv[$];
    obs_t o;
    exp_t e;
    tv.push_back(mk(1, 0, 3'b010, 32'h400, 32'h0, 32'h99999999, -1));
    tv.push_back(mk(1, 0, 3'b010, 32'h404, 32'h0, 32'h12121212, 3));
    tv.push_back(mk(0, 1, 3'b010, 32'h408, 32'hABCD0123, 32'h0, -1));
    tv.push_back(mk(1, 0, 3'b000, 32'h40C, 32'h0, 32'h000000F0, 4));
    foreach (tv[i]) begin
      sb.push_back(model(tv[i], model_rd));
      run_access(tv[i], o);
      e = sb.pop_front();
      model_rd = e.rdata;
      checks++;
      if (o.stalls !== e.stalls) begin
        failures++; $display("FAIL timeout[%0d] stall_cycles got=%0d exp=%0d", i, o.stalls, e.stalls);
      end
      checks++;
      if ({o.rdata, o.mis, o.err} !== {e.rdata, e.mis, e.err}) begin
        failures++; $display("FAIL timeout[%0d] result got rdata=%h mis=%b err=%b exp rdata=%h mis=%b err=%b",
                             i, o.rdata, o.mis, o.err, e.rdata, e.mis, e.err);
      end
      checks++;
      if ({o.post_mis, o.post_err, o.post_req} !== 3'b000) begin
        failures++; $display("FAIL timeout[%0d] after_done got mis=%b err=%b req=%b exp 0 0 0", i, o.post_mis, o.post_err, o.post_req);
      end
    end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL global_time_limit got=expired exp=finished");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_loads();
    test_reset_busy();
    test_stores();
    test_misalign();
    test_mixed();
`ifdef DMEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
